// File: rtl/dvalid_capture_pkg.sv
// Shared width derivations and drop-counter constants for the dvalid capture FIFO.
package dvalid_capture_pkg;

   localparam int unsigned DROP_CNT_W = 16;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

   function automatic int unsigned addr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Occupancy must represent DEPTH itself, hence one extra bit.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/capture_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset on storage.
module capture_fifo_mem
   import dvalid_capture_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [addr_w(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]           wdata,
   input  logic [addr_w(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]           rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dvalid_capture_fifo.sv
// Non-stalling capture buffer for DATA_OUT/DVALID words with ready/valid read-out.
// Optional DROP_CNT output enabled by defining CAPTURE_FIFO_DROP_CNT_EN.
module dvalid_capture_fifo
   import dvalid_capture_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AFULL_LVL = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [level_w(DEPTH)-1:0]  level,
   output logic                       afull,
   output logic                       overflow,
   input  logic                       clear_ovf
`ifdef CAPTURE_FIFO_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0]      drop_cnt
`endif
);

   localparam int unsigned ADDR_W  = addr_w(DEPTH);
   localparam int unsigned LEVEL_W = level_w(DEPTH);
   localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0] AF_LVL   = LEVEL_W'(AFULL_LVL);

   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               afull_q, afull_d;
   logic               overflow_q, overflow_d;
   logic               full, push, pop, drop;
   logic [WIDTH-1:0]   rd_data;

   assign out_valid = (level_q != '0);
   assign full      = (level_q == FULL_LVL);
   assign pop       = out_valid && out_ready;
   // A pop frees the slot in the same cycle, so a full buffer still accepts.
   assign push      = in_valid && (!full || pop);
   assign drop      = in_valid && full && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LEVEL_W'(1);
         2'b01:   level_d = level_q - LEVEL_W'(1);
         default: level_d = level_q;
      endcase
      afull_d = (level_d >= AF_LVL);
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clear_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         afull_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         afull_q    <= afull_d;
         overflow_q <= overflow_d;
      end
   end

   capture_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   assign out_data = out_valid ? rd_data : '0;
   assign level    = level_q;
   assign afull    = afull_q;
   assign overflow = overflow_q;

`ifdef CAPTURE_FIFO_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clear_ovf) begin
         drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
      end else if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dvalid_capture_fifo.sv
// Scoreboard bench for dvalid_capture_fifo (WIDTH=8, DEPTH=4, AFULL_LVL=3).
module tb_dvalid_capture_fifo;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AFULL_LVL = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2:0]       level;
   logic             afull;
   logic             overflow;
   logic             clear_ovf = 1'b0;
`ifdef CAPTURE_FIFO_DROP_CNT_EN
   logic [15:0]      drop_cnt;
`endif

   int n_checks = 0;
   int n_fail = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   dvalid_capture_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .afull     (afull),
      .overflow  (overflow),
      .clear_ovf (clear_ovf)
`ifdef CAPTURE_FIFO_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are held across one rising edge; returns 1 time unit after that edge.
   task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clear_ovf = c;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clear_ovf = 1'b0;
   endtask

   // Monitor: a handshake seen at the falling edge completes on the next rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
               end else begin
                  chk("out_word", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
               end
            end else if (!out_valid) begin
               chk("out_data_masked", {24'h0, out_data}, 32'h0);
            end
         end
      end
   end

   initial begin
      logic [2:0] lvl_exp [5];
      lvl_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_level", {29'h0, level}, 32'h0);
      chk("rst_out_data", {24'h0, out_data}, 32'h0);
      chk("rst_overflow", {31'h0, overflow}, 32'h0);
      chk("rst_afull", {31'h0, afull}, 32'h0);
      @(posedge clk);
      #1;

      // Single word with fall-through
      exp_q.push_back(8'hA5);
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("single_valid", {31'h0, out_valid}, 32'h1);
      chk("single_data", {24'h0, out_data}, 32'hA5);
      chk("single_level", {29'h0, level}, 32'h1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("single_pop_level", {29'h0, level}, 32'h0);
      chk("single_pop_valid", {31'h0, out_valid}, 32'h0);

      // Fill and overflow: 05 is dropped
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q.push_back(WIDTH'(i));
         cyc(1'b1, WIDTH'(i), 1'b0, 1'b0);
         chk("fill_level", {29'h0, level}, {29'h0, lvl_exp[i-1]});
         chk("fill_afull", {31'h0, afull}, (i >= 3) ? 32'h1 : 32'h0);
      end
      chk("fill_overflow", {31'h0, overflow}, 32'h1);
      chk("fill_head", {24'h0, out_data}, 32'h01);
`ifdef CAPTURE_FIFO_DROP_CNT_EN
      chk("fill_drop_cnt", {16'h0, drop_cnt}, 32'h1);
`endif
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_level", {29'h0, level}, 32'(3 - i));
         chk("drain_afull", {31'h0, afull}, (i == 0) ? 32'h1 : 32'h0);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clear_overflow", {31'h0, overflow}, 32'h0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h21 + WIDTH'(i));
         cyc(1'b1, 8'h21 + WIDTH'(i), 1'b0, 1'b0);
      end
      chk("full_level", {29'h0, level}, 32'h4);
      exp_q.push_back(8'hEE);
      cyc(1'b1, 8'hEE, 1'b1, 1'b0);
      chk("pushpop_level", {29'h0, level}, 32'h4);
      chk("pushpop_overflow", {31'h0, overflow}, 32'h0);
      chk("pushpop_head", {24'h0, out_data}, 32'h22);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pushpop_empty", {29'h0, level}, 32'h0);

      // Pointer wrap streaming
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(8'h10 + WIDTH'(i));
         cyc(1'b1, 8'h10 + WIDTH'(i), 1'b1, 1'b0);
         chk("stream_level", {29'h0, level}, 32'h1);
         chk("stream_head", {24'h0, out_data}, {24'h0, 8'h10 + WIDTH'(i)});
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("stream_done_level", {29'h0, level}, 32'h0);
      chk("stream_all_delivered", 32'(exp_q.size()), 32'h0);

      // Clear priority: a drop coincident with clear keeps OVERFLOW set
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h31 + WIDTH'(i));
         cyc(1'b1, 8'h31 + WIDTH'(i), 1'b0, 1'b0);
      end
      cyc(1'b1, 8'h99, 1'b0, 1'b0);
      chk("prio_ovf_set", {31'h0, overflow}, 32'h1);
      cyc(1'b1, 8'h98, 1'b0, 1'b1);
      chk("prio_set_wins", {31'h0, overflow}, 32'h1);
`ifdef CAPTURE_FIFO_DROP_CNT_EN
      chk("prio_drop_cnt", {16'h0, drop_cnt}, 32'h1);
`endif
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("prio_cleared", {31'h0, overflow}, 32'h0);
`ifdef CAPTURE_FIFO_DROP_CNT_EN
      chk("prio_drop_cnt_clr", {16'h0, drop_cnt}, 32'h0);
`endif
      chk("prio_level_held", {29'h0, level}, 32'h4);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_level", {29'h0, level}, 32'h3);

      // Asynchronous reset mid-stream, checked before any clock edge
      rst_n = 1'b0;
      #1;
      chk("async_rst_level", {29'h0, level}, 32'h0);
      chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
      chk("async_rst_data", {24'h0, out_data}, 32'h0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back(8'h77);
      cyc(1'b1, 8'h77, 1'b0, 1'b0);
      chk("post_rst_data", {24'h0, out_data}, 32'h77);
      chk("post_rst_level", {29'h0, level}, 32'h1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
